// File: rtl/shift_counter_cfg_if.sv
// ---------------------------------------------------------------------------
// shift_counter_cfg_if
//
// Purpose: groups the control and status signals of shift_counter_cfg so the
// counter and whoever drives it share one bundle.
//
// Signals (Q[1] and d[1] are the leftmost bits, and the MSB in binary mode):
//   en    - count enable
//   load  - parallel load strobe, wins over en
//   d     - parallel load value [1:N]
//   mode  - 00 ring, 01 Johnson, 10 LFSR, 11 binary
//   dir   - 0 shift toward Q[N] / count up, 1 shift toward Q[1] / count down
//   Q     - counter state [1:N]
//   tc    - registered terminal-count pulse
//   err   - combinational illegal-state flag
//
// Modports:
//   master - the controller: drives en/load/d/mode/dir, observes Q/tc/err
//   slave  - the counter: the reverse
// ---------------------------------------------------------------------------
interface shift_counter_cfg_if #(
    parameter int N = 4
);

    logic         en;
    logic         load;
    logic [1:N]   d;
    logic [1:0]   mode;
    logic         dir;
    logic [1:N]   Q;
    logic         tc;
    logic         err;

    modport master (
        output en, load, d, mode, dir,
        input  Q, tc, err
    );

    modport slave (
        input  en, load, d, mode, dir,
        output Q, tc, err
    );

endinterface

// File: rtl/shift_counter_cfg.sv
// ---------------------------------------------------------------------------
// shift_counter_cfg
//
// Purpose: run-time configurable shift-register counter. It supports ring,
// Johnson (twisted ring), Fibonacci LFSR and binary up/down modes, with
// parallel load, a registered terminal-count pulse and illegal-state
// detection. An enabled edge from an illegal state reloads the seed of the
// current mode.
//
// Parameters:
//   N          - counter width (N >= 2)
//   TAPS       - LFSR tap mask, bit i selects Q[i+1]
//   INIT_MODE  - mode whose seed is loaded while reset_n is low
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   bus        - slave side of shift_counter_cfg_if (en, load, d, mode, dir
//                in; Q, tc, err out)
// ---------------------------------------------------------------------------
module shift_counter_cfg #(
    parameter int             N         = 4,
    parameter logic [N-1:0]   TAPS      = 4'b1100,
    parameter logic [1:0]     INIT_MODE = 2'b00
) (
    input  logic               clk,
    input  logic               reset_n,
    shift_counter_cfg_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_BINARY  = 2'b11
    } mode_t;

    // Ring and LFSR start from a single one at Q[1]. Johnson and binary
    // start from all zeros.
    function automatic logic [1:N] seedOf(input mode_t m);
        logic [1:N] s;
        s = '0;
        if ((m == MODE_RING) || (m == MODE_LFSR)) begin
            s[1] = 1'b1;
        end
        return s;
    endfunction

    logic [1:N]   r_q;
    logic         r_tc;

    mode_t        w_mode;
    logic [1:N]   w_seed;
    logic [1:N-1] w_edges;
    logic         w_feedback;
    logic         w_legal;
    logic [1:N]   w_step;
    logic         w_wrap;
    logic [1:N]   w_nextQ;
    logic         w_nextTc;

    assign w_mode  = mode_t'(bus.mode);
    assign w_seed  = seedOf(w_mode);

    // Each set bit marks a boundary between neighbouring bits that differ.
    // A legal Johnson word has at most one such boundary.
    assign w_edges = r_q[1:N-1] ^ r_q[2:N];

    // Fibonacci feedback: parity of the tapped bits, TAPS[i] picks Q[i+1].
    always_comb begin
        w_feedback = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_feedback = w_feedback ^ (TAPS[i] & r_q[i+1]);
        end
    end

    // Legality of the present word under the presently selected mode.
    // A mode change re-evaluates this at once, so err follows without a clock.
    always_comb begin
        w_legal = 1'b1;
        case (w_mode)
            MODE_RING:    w_legal = ($countones(r_q) == 1);
            MODE_JOHNSON: w_legal = ($countones(w_edges) <= 1);
            MODE_LFSR:    w_legal = |r_q;
            default:      w_legal = 1'b1;
        endcase
    end

    // The successor of a legal word. The LFSR always shifts toward Q[N],
    // whatever dir says.
    always_comb begin
        w_step = r_q;
        case (w_mode)
            MODE_RING: begin
                if (bus.dir) begin
                    w_step = {r_q[2:N], r_q[1]};
                end else begin
                    w_step = {r_q[N], r_q[1:N-1]};
                end
            end
            MODE_JOHNSON: begin
                if (bus.dir) begin
                    w_step = {r_q[2:N], ~r_q[1]};
                end else begin
                    w_step = {~r_q[N], r_q[1:N-1]};
                end
            end
            MODE_LFSR: begin
                w_step = {w_feedback, r_q[1:N-1]};
            end
            default: begin
                if (bus.dir) begin
                    w_step = r_q - 1'b1;
                end else begin
                    w_step = r_q + 1'b1;
                end
            end
        endcase
    end

    // A sequence wraps when it returns to its seed. Binary wraps when it
    // crosses between all ones and zero, in the direction of counting.
    always_comb begin
        w_wrap = 1'b0;
        if (w_mode == MODE_BINARY) begin
            if (bus.dir) begin
                w_wrap = (r_q == '0);
            end else begin
                w_wrap = (r_q == '1);
            end
        end else begin
            w_wrap = (w_step == w_seed);
        end
    end

    // Load beats enable, and enable beats hold. A load takes d as given,
    // even an illegal value. An enabled edge from an illegal word
    // reseeds the counter.
    always_comb begin
        w_nextQ  = r_q;
        w_nextTc = 1'b0;
        if (bus.load) begin
            w_nextQ = bus.d;
        end else if (bus.en) begin
            if (w_legal) begin
                w_nextQ  = w_step;
                w_nextTc = w_wrap;
            end else begin
                w_nextQ  = w_seed;
            end
        end
    end

    // Reset loads the seed of INIT_MODE without waiting for the clock and
    // clears any pending terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q  <= seedOf(mode_t'(INIT_MODE));
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_nextQ;
            r_tc <= w_nextTc;
        end
    end

    assign bus.Q   = r_q;
    assign bus.tc  = r_tc;
    assign bus.err = ~w_legal;

endmodule

// File: tb/tb_shift_counter_cfg.sv
// ---------------------------------------------------------------------------
// tb_shift_counter_cfg
//
// Purpose: self-checking bench for shift_counter_cfg (N=4, TAPS=1100,
// INIT_MODE=00). It runs directed sequences followed by randomized traffic.
// Every cycle is compared against an integer reference model. In that model
// Q[1] is bit N-1 of a plain int.
// ---------------------------------------------------------------------------
module tb_shift_counter_cfg;

    localparam int           N       = 4;
    localparam logic [N-1:0] TB_TAPS = 4'b1100;
    localparam int           MASK    = (1 << N) - 1;

    logic clk = 1'b0;
    logic reset_n;

    int totalCount = 0;
    int badCount   = 0;
    int modelQ     = 0;
    int modelTc    = 0;

    shift_counter_cfg_if #(.N(N)) bus ();

    shift_counter_cfg #(
        .N         (N),
        .TAPS      (TB_TAPS),
        .INIT_MODE (2'b00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model, built from integer arithmetic on the state value.
    function automatic int seedOf(input int m);
        return ((m == 0) || (m == 2)) ? (1 << (N - 1)) : 0;
    endfunction

    function automatic int tapMask();
        int msk;
        logic [N-1:0] t;
        msk = 0;
        t   = TB_TAPS;
        for (int i = 0; i < N; i++) begin
            if (t[i]) msk = msk | (1 << (N - 1 - i));
        end
        return msk;
    endfunction

    function automatic bit legalOf(input int v, input int m);
        case (m)
            0:       return $countones(v) == 1;
            1:       return $countones((v ^ (v >> 1)) & (MASK >> 1)) <= 1;
            2:       return v != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int advance(input int v, input int m, input int dr);
        int fb;
        case (m)
            0: return (dr == 0) ? ((v >> 1) | ((v & 1) << (N - 1)))
                                : (((v << 1) & MASK) | (v >> (N - 1)));
            1: return (dr == 0) ? ((v >> 1) | (((~v) & 1) << (N - 1)))
                                : (((v << 1) & MASK) | (((~v) >> (N - 1)) & 1));
            2: begin
                fb = $countones(v & tapMask()) & 1;
                return (v >> 1) | (fb << (N - 1));
            end
            default: return (dr == 0) ? ((v + 1) & MASK) : ((v - 1) & MASK);
        endcase
    endfunction

    task automatic modelClock(input int e, input int l, input int dv, input int m, input int dr);
        int nxt;
        bit wrap;
        if (l != 0) begin
            modelQ  = dv & MASK;
            modelTc = 0;
        end else if (e != 0) begin
            if (legalOf(modelQ, m)) begin
                nxt = advance(modelQ, m, dr);
                if (m == 3) wrap = (dr != 0) ? (modelQ == 0) : (modelQ == MASK);
                else        wrap = (nxt == seedOf(m));
                modelQ  = nxt;
                modelTc = wrap ? 1 : 0;
            end else begin
                modelQ  = seedOf(m);
                modelTc = 0;
            end
        end else begin
            modelTc = 0;
        end
    endtask

    // Every comparison in the bench goes through this task.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalCount++;
        if (observed != expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, clocks the DUT and the model, then compares
    // Q, tc and err just after the edge.
    task automatic applyStimulus(input int e, input int l, input int dv, input int m,
                                 input int dr, input string tag);
        logic [N-1:0] dBits;
        logic [1:0]   mBits;
        dBits    = dv[N-1:0];
        mBits    = m[1:0];
        bus.en   = e[0];
        bus.load = l[0];
        bus.d    = dBits;
        bus.mode = mBits;
        bus.dir  = dr[0];
        @(posedge clk);
        modelClock(e, l, dv, m, dr);
        #1;
        checkOutput({tag, ".Q"},   int'(bus.Q),   modelQ);
        checkOutput({tag, ".tc"},  int'(bus.tc),  modelTc);
        checkOutput({tag, ".err"}, int'(bus.err), legalOf(modelQ, m) ? 0 : 1);
    endtask

    initial begin
        int ringUp [4]  = '{4, 2, 1, 8};
        int ringDn [4]  = '{1, 2, 4, 8};
        int john   [8]  = '{8, 12, 14, 15, 7, 3, 1, 0};
        int lfsr   [15] = '{4, 2, 9, 12, 6, 11, 5, 10, 13, 14, 15, 7, 3, 1, 8};
        int curMode;
        int curDir;

        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.d    = '0;
        bus.mode = 2'b00;
        bus.dir  = 1'b0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset.Q",   int'(bus.Q),   8);
        checkOutput("reset.tc",  int'(bus.tc),  0);
        checkOutput("reset.err", int'(bus.err), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        modelQ  = seedOf(0);
        modelTc = 0;

        // Ring wrap in both directions.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, "ringUp");
            checkOutput("ringUp.lit",   int'(bus.Q),  ringUp[i]);
            checkOutput("ringUp.tcLit", int'(bus.tc), (i == 3) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 1, "ringDn");
            checkOutput("ringDn.lit",   int'(bus.Q),  ringDn[i]);
            checkOutput("ringDn.tcLit", int'(bus.tc), (i == 3) ? 1 : 0);
        end

        // Johnson period from all zeros.
        applyStimulus(0, 1, 0, 1, 0, "johnLoad");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 1, 0, "john");
            checkOutput("john.lit",    int'(bus.Q),   john[i]);
            checkOutput("john.tcLit",  int'(bus.tc),  (i == 7) ? 1 : 0);
            checkOutput("john.errLit", int'(bus.err), 0);
        end

        // LFSR maximal-length period.
        applyStimulus(0, 1, 8, 2, 0, "lfsrLoad");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 0, 0, 2, 0, "lfsr");
            checkOutput("lfsr.lit",   int'(bus.Q),  lfsr[i]);
            checkOutput("lfsr.tcLit", int'(bus.tc), (i == 14) ? 1 : 0);
        end

        // LFSR lockup and its recovery.
        applyStimulus(0, 1, 0, 2, 0, "lockLoad");
        checkOutput("lock.errLit", int'(bus.err), 1);
        applyStimulus(1, 0, 0, 2, 0, "lockFix");
        checkOutput("lockFix.lit", int'(bus.Q), 8);
        checkOutput("lockFix.tcLit", int'(bus.tc), 0);

        // Illegal ring word held, then corrected.
        applyStimulus(0, 1, 10, 0, 0, "ringBadLoad");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, "ringBadHold");
            checkOutput("ringBadHold.lit", int'(bus.Q),   10);
            checkOutput("ringBadHold.err", int'(bus.err), 1);
        end
        applyStimulus(1, 0, 0, 0, 0, "ringBadFix");
        checkOutput("ringBadFix.lit", int'(bus.Q),   8);
        checkOutput("ringBadFix.err", int'(bus.err), 0);

        // A mode change raises err with no clock edge.
        applyStimulus(0, 1, 0, 3, 0, "modeChgLoad");
        checkOutput("modeChg.errBefore", int'(bus.err), 0);
        bus.mode = 2'b00;
        #1;
        checkOutput("modeChg.errAfter", int'(bus.err), 1);
        applyStimulus(1, 0, 0, 0, 0, "modeChgFix");

        // Binary wraps, then asynchronous reset in the middle of a cycle.
        applyStimulus(0, 1, 0, 3, 0, "binLoad");
        applyStimulus(1, 0, 0, 3, 1, "binDnWrap");
        checkOutput("binDnWrap.lit", int'(bus.Q),  15);
        checkOutput("binDnWrap.tc",  int'(bus.tc), 1);
        applyStimulus(1, 0, 0, 3, 0, "binUpWrap");
        checkOutput("binUpWrap.lit", int'(bus.Q),  0);
        checkOutput("binUpWrap.tc",  int'(bus.tc), 1);
        applyStimulus(1, 0, 0, 3, 1, "binDnWrap2");
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncRst.Q",  int'(bus.Q),  8);
        checkOutput("asyncRst.tc", int'(bus.tc), 0);
        @(posedge clk);
        #1;
        checkOutput("rstHeld.Q", int'(bus.Q), 8);
        reset_n = 1'b1;
        modelQ  = seedOf(0);
        modelTc = 0;
        applyStimulus(1, 0, 0, 3, 0, "postRst");

        // Randomized traffic against the model.
        curMode = 0;
        curDir  = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 15) curMode = $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 20) curDir  = $urandom_range(0, 1);
            applyStimulus(($urandom_range(0, 99) < 75) ? 1 : 0,
                          ($urandom_range(0, 99) < 10) ? 1 : 0,
                          $urandom_range(0, MASK), curMode, curDir, "rand");
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
